// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN,
    LDUSE,
    FLUSH
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A writer to x0 never produces a value anyone can consume.
  function automatic logic reg_hit(input logic [4:0] rd, input logic wren, input logic [4:0] rs);
    return wren && (rd != REG_X0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - EX operand forwarding selects and WB->ID regfile bypass compare
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs1_addr,
  input  logic [4:0] ex_rs2_addr,
  input  logic [4:0] mem_rd_addr,
  input  logic       mem_rd_wren,
  input  logic [4:0] wb_rd_addr,
  input  logic       wb_rd_wren,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       sel_rs1_wb,
  output logic       sel_rs2_wb
);

  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (reg_hit(mem_rd_addr, mem_rd_wren, ex_rs1_addr)) begin
      fwd_a = FWD_MEM;
    end else if (reg_hit(wb_rd_addr, wb_rd_wren, ex_rs1_addr)) begin
      fwd_a = FWD_WB;
    end
    if (reg_hit(mem_rd_addr, mem_rd_wren, ex_rs2_addr)) begin
      fwd_b = FWD_MEM;
    end else if (reg_hit(wb_rd_addr, wb_rd_wren, ex_rs2_addr)) begin
      fwd_b = FWD_WB;
    end
  end

  assign fwd_a_sel  = fwd_a;
  assign fwd_b_sel  = fwd_b;
  assign sel_rs1_wb = reg_hit(wb_rd_addr, wb_rd_wren, id_rs1_addr);
  assign sel_rs2_wb = reg_hit(wb_rd_addr, wb_rd_wren, id_rs2_addr);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline sequencer: load-use/redirect/LSU-wait hazards and perf counters
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LD_STALL  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rd_rs2_en,
  input  logic [4:0]       ex_rs1_addr,
  input  logic [4:0]       ex_rs2_addr,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_rd_wren,
  input  logic             ex_ld_en,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd_addr,
  input  logic             mem_rd_wren,
  input  logic [4:0]       wb_rd_addr,
  input  logic             wb_rd_wren,
  input  logic             lsu_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush_n,
  output logic             id_ex_en,
  output logic             id_ex_flush_n,
  output logic             ex_mem_en,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             sel_rs1_wb,
  output logic             sel_rs2_wb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       lu;
  logic       flush_acc;
  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       rs1_wb_raw, rs2_wb_raw;

  fwd_unit u_fwd (
    .ex_rs1_addr (ex_rs1_addr),
    .ex_rs2_addr (ex_rs2_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_wren (mem_rd_wren),
    .wb_rd_addr  (wb_rd_addr),
    .wb_rd_wren  (wb_rd_wren),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .fwd_a_sel   (fwd_a_raw),
    .fwd_b_sel   (fwd_b_raw),
    .sel_rs1_wb  (rs1_wb_raw),
    .sel_rs2_wb  (rs2_wb_raw)
  );

  assign fwd_a_sel  = rst_n ? fwd_a_raw : 2'b00;
  assign fwd_b_sel  = rst_n ? fwd_b_raw : 2'b00;
  assign sel_rs1_wb = rst_n & rs1_wb_raw;
  assign sel_rs2_wb = rst_n & rs2_wb_raw;

  assign lu = ex_ld_en & (reg_hit(ex_rd_addr, ex_rd_wren, id_rs1_addr) |
                          (id_rd_rs2_en & reg_hit(ex_rd_addr, ex_rd_wren, id_rs2_addr)));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flush_acc     = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush_n = 1'b1;
    id_ex_en      = 1'b1;
    id_ex_flush_n = 1'b1;
    ex_mem_en     = 1'b1;
    if (!rst_n) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush_n = 1'b0;
      id_ex_en      = 1'b0;
      id_ex_flush_n = 1'b0;
      ex_mem_en     = 1'b0;
    end else if (lsu_busy) begin
      // Whole pipe holds in place; sequencer state is left untouched.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else begin
      case (state_q)
        RUN, LDUSE: begin
          if (ex_redirect) begin
            if_id_flush_n = 1'b0;
            id_ex_flush_n = 1'b0;
            flush_acc     = 1'b1;
            if (FLUSH_CYC > 1) begin
              state_d = FLUSH;
              cnt_d   = 2'(FLUSH_CYC - 1);
            end else begin
              state_d = RUN;
            end
          end else if (state_q == LDUSE || lu) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_flush_n = 1'b0;
            if (state_q == LDUSE) begin
              cnt_d = cnt_q - 2'd1;
              if (cnt_q == 2'd1) state_d = RUN;
            end else if (LD_STALL > 1) begin
              state_d = LDUSE;
              cnt_d   = 2'(LD_STALL - 1);
            end
          end
        end
        FLUSH: begin
          // The EX slot is already a bubble here, so its redirect is meaningless.
          if_id_flush_n = 1'b0;
          id_ex_flush_n = 1'b0;
          cnt_d         = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_acc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with two parameterisations
module tb_hazard_ctrl;

  localparam logic [5:0] C_RST = 6'b000000;
  localparam logic [5:0] C_RUN = 6'b111111;
  localparam logic [5:0] C_LU  = 6'b001101;
  localparam logic [5:0] C_RD  = 6'b110101;
  localparam logic [5:0] C_FZ  = 6'b001010;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [4:0] mem_rd_addr, wb_rd_addr;
  logic id_rd_rs2_en, ex_rd_wren, ex_ld_en, ex_redirect, mem_rd_wren, wb_rd_wren, lsu_busy;

  logic a_pc, a_ifen, a_iffl, a_ixen, a_ixfl, a_emen, a_s1, a_s2;
  logic b_pc, b_ifen, b_iffl, b_ixen, b_ixfl, b_emen, b_s1, b_s2;
  logic [1:0] a_fa, a_fb, b_fa, b_fb;
  logic [31:0] a_st, a_fl;
  logic [2:0]  b_st, b_fl;

  always #5 clk = ~clk;

  hazard_ctrl #(.LD_STALL(1), .FLUSH_CYC(2), .CNT_W(32)) dut_a (
    .clk_i(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_rs2_en(id_rd_rs2_en),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_rd_wren(ex_rd_wren), .ex_ld_en(ex_ld_en), .ex_redirect(ex_redirect),
    .mem_rd_addr(mem_rd_addr), .mem_rd_wren(mem_rd_wren),
    .wb_rd_addr(wb_rd_addr), .wb_rd_wren(wb_rd_wren), .lsu_busy(lsu_busy),
    .pc_en(a_pc), .if_id_en(a_ifen), .if_id_flush_n(a_iffl), .id_ex_en(a_ixen),
    .id_ex_flush_n(a_ixfl), .ex_mem_en(a_emen), .fwd_a_sel(a_fa), .fwd_b_sel(a_fb),
    .sel_rs1_wb(a_s1), .sel_rs2_wb(a_s2), .stall_cnt(a_st), .flush_cnt(a_fl)
  );

  hazard_ctrl #(.LD_STALL(2), .FLUSH_CYC(2), .CNT_W(3)) dut_b (
    .clk_i(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_rs2_en(id_rd_rs2_en),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_rd_wren(ex_rd_wren), .ex_ld_en(ex_ld_en), .ex_redirect(ex_redirect),
    .mem_rd_addr(mem_rd_addr), .mem_rd_wren(mem_rd_wren),
    .wb_rd_addr(wb_rd_addr), .wb_rd_wren(wb_rd_wren), .lsu_busy(lsu_busy),
    .pc_en(b_pc), .if_id_en(b_ifen), .if_id_flush_n(b_iffl), .id_ex_en(b_ixen),
    .id_ex_flush_n(b_ixfl), .ex_mem_en(b_emen), .fwd_a_sel(b_fa), .fwd_b_sel(b_fb),
    .sel_rs1_wb(b_s1), .sel_rs2_wb(b_s2), .stall_cnt(b_st), .flush_cnt(b_fl)
  );

  typedef struct {
    int         cyc;
    string      name;
    bit         dut;
    logic [11:0] outs;
    int         st;
    int         fl;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input string name, input bit dut, input logic [5:0] ctl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic s1, input logic s2,
                      input int st, input int fl);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.dut  = dut;
    e.outs = {ctl, fa, fb, s1, s2};
    e.st   = st;
    e.fl   = fl;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_rs2_en = 0;
    ex_rs1_addr = 0; ex_rs2_addr = 0; ex_rd_addr = 0;
    ex_rd_wren = 0; ex_ld_en = 0; ex_redirect = 0;
    mem_rd_addr = 0; mem_rd_wren = 0; wb_rd_addr = 0; wb_rd_wren = 0;
    lsu_busy = 0;
  endtask

  // lw x5 in EX, add x6,x5,x1 in ID
  task automatic lu_in();
    ex_ld_en = 1; ex_rd_wren = 1; ex_rd_addr = 5;
    id_rs1_addr = 5; id_rs2_addr = 1; id_rd_rs2_en = 1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [11:0] act;
      int ast, afl;
      e = q.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
      end else begin
        act = e.dut ? {b_pc, b_ifen, b_iffl, b_ixen, b_ixfl, b_emen, b_fa, b_fb, b_s1, b_s2}
                    : {a_pc, a_ifen, a_iffl, a_ixen, a_ixfl, a_emen, a_fa, a_fb, a_s1, a_s2};
        if (act !== e.outs) begin
          n_bad++;
          $display("FAIL %s: outputs got %b want %b", e.name, act, e.outs);
        end
        if (e.st >= 0) begin
          ast = e.dut ? int'(b_st) : int'(a_st);
          afl = e.dut ? int'(b_fl) : int'(a_fl);
          n_cmp++;
          if (ast != e.st || afl != e.fl) begin
            n_bad++;
            $display("FAIL %s_cnt: stall/flush got %0d/%0d want %0d/%0d", e.name, ast, afl, e.st, e.fl);
          end
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst_n = 0;
    @(posedge clk); #1;
    step("rst_a", 0, C_RST, 2'b00, 2'b00, 0, 0, 0, 0);
    mem_rd_addr = 5; mem_rd_wren = 1; ex_rs1_addr = 5; wb_rd_addr = 3; wb_rd_wren = 1; id_rs1_addr = 3;
    step("rst_fwd", 1, C_RST, 2'b00, 2'b00, 0, 0, 0, 0);

    clr(); rst_n = 1; lu_in();
    step("s1_bubble", 0, C_LU, 2'b00, 2'b00, 0, 0, 0, 0);
    clr(); mem_rd_addr = 5; mem_rd_wren = 1; ex_rs1_addr = 5; ex_rs2_addr = 1;
    step("s1_fwd", 0, C_RUN, 2'b01, 2'b00, 0, 0, 1, 0);
    clr(); rst_n = 0;
    step("s1_rst", 0, C_RST, 2'b00, 2'b00, 0, 0, 1, 0);
    rst_n = 1;
    step("s1_clr", 0, C_RUN, 2'b00, 2'b00, 0, 0, 0, 0);

    lu_in();
    step("s2_b1", 1, C_LU, 2'b00, 2'b00, 0, 0, 0, 0);
    clr(); mem_rd_addr = 5; mem_rd_wren = 1; id_rs1_addr = 5; id_rs2_addr = 1; id_rd_rs2_en = 1;
    step("s2_b2", 1, C_LU, 2'b00, 2'b00, 0, 0, 1, 0);
    clr(); wb_rd_addr = 5; wb_rd_wren = 1; ex_rs1_addr = 5; ex_rs2_addr = 1;
    step("s2_fwd", 1, C_RUN, 2'b10, 2'b00, 0, 0, 2, 0);
    clr();
    step("s2_done", 1, C_RUN, 2'b00, 2'b00, 0, 0, 2, 0);

    ex_redirect = 1;
    step("s3_redir", 1, C_RD, 2'b00, 2'b00, 0, 0, 2, 0);
    step("s3_ignored", 1, C_RD, 2'b00, 2'b00, 0, 0, 2, 1);
    ex_redirect = 0;
    step("s3_run", 1, C_RUN, 2'b00, 2'b00, 0, 0, 2, 1);

    lu_in();
    step("s4_lu", 1, C_LU, 2'b00, 2'b00, 0, 0, 2, 1);
    clr(); lsu_busy = 1;
    step("s4_fz0", 1, C_FZ, 2'b00, 2'b00, 0, 0, 3, 1);
    step("s4_fz1", 1, C_FZ, 2'b00, 2'b00, 0, 0, 4, 1);
    step("s4_fz2", 1, C_FZ, 2'b00, 2'b00, 0, 0, 5, 1);
    lsu_busy = 0;
    step("s4_resume", 1, C_LU, 2'b00, 2'b00, 0, 0, 6, 1);
    step("s4_run", 1, C_RUN, 2'b00, 2'b00, 0, 0, 7, 1);

    lsu_busy = 1;
    step("sat0", 1, C_FZ, 2'b00, 2'b00, 0, 0, 7, 1);
    step("sat1", 1, C_FZ, 2'b00, 2'b00, 0, 0, 7, 1);
    lsu_busy = 0;
    step("sat_run", 1, C_RUN, 2'b00, 2'b00, 0, 0, 7, 1);

    lsu_busy = 1; ex_redirect = 1;
    step("fz_redir", 1, C_FZ, 2'b00, 2'b00, 0, 0, 7, 1);
    lsu_busy = 0; ex_redirect = 0;
    step("fz_redir_run", 1, C_RUN, 2'b00, 2'b00, 0, 0, 7, 1);

    lu_in(); ex_redirect = 1;
    step("redir_lu", 1, C_RD, 2'b00, 2'b00, 0, 0, 7, 1);
    ex_redirect = 0;
    step("flush_lu", 1, C_RD, 2'b00, 2'b00, 0, 0, 7, 2);
    clr();
    step("post_flush", 1, C_RUN, 2'b00, 2'b00, 0, 0, 7, 2);

    mem_rd_addr = 7; mem_rd_wren = 1; wb_rd_addr = 7; wb_rd_wren = 1;
    ex_rs1_addr = 7; ex_rs2_addr = 0; id_rs1_addr = 3; id_rs2_addr = 7;
    step("s5_memwins", 0, C_RUN, 2'b01, 2'b00, 0, 1, -1, -1);
    mem_rd_wren = 0;
    step("s5_wb", 0, C_RUN, 2'b10, 2'b00, 0, 1, -1, -1);
    clr(); mem_rd_wren = 1; wb_rd_wren = 1; ex_ld_en = 1; ex_rd_wren = 1;
    step("s5_x0", 0, C_RUN, 2'b00, 2'b00, 0, 0, -1, -1);
    clr(); ex_rs2_addr = 9; wb_rd_addr = 9; wb_rd_wren = 1; id_rs1_addr = 9;
    step("s5_fwdb", 0, C_RUN, 2'b00, 2'b10, 1, 0, -1, -1);

    clr(); lu_in();
    step("s6_lu", 1, C_LU, 2'b00, 2'b00, 0, 0, 7, 2);
    rst_n = 0;
    step("s6_rst", 1, C_RST, 2'b00, 2'b00, 0, 0, -1, -1);
    rst_n = 1; clr(); ex_ld_en = 1; ex_rd_wren = 1;
    step("s6_run", 1, C_RUN, 2'b00, 2'b00, 0, 0, 0, 0);

    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
